mem_stage: RTL

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 271 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage.
// Latches one instruction from EX, issues at most one data-SRAM request for
// it, extracts/sign-extends load data and hands the result to WB.
//
// Handshake semantics (all interfaces):
//   EX  -> MEM : the EX bundle is taken on a rising edge where
//                EX_to_MEM & MEM_allowin.
//   MEM -> WB  : the result is handed over on a rising edge where
//                MEM_to_WB (= DONE & WB_allowin).
//   MEM -> SRAM: data_sram_req is asserted only in REQ and every request
//                field holds stable until a rising edge with data_sram_addr_ok;
//                the response is taken on the first data_sram_data_ok after
//                that (data_ok together with addr_ok counts as both).
module mem_stage (
  input  logic         clk,
  input  logic         rst,
  input  logic [144:0] EX_to_MEM_zip,
  input  logic [86:0]  EX_except_zip,
  input  logic         EX_to_MEM,
  input  logic         WB_allowin,
  input  logic         flush,
  output logic         MEM_allowin,
  output logic         MEM_to_WB,
  output logic [102:0] MEM_to_WB_reg,
  output logic [86:0]  MEM_except_reg,
  output logic         data_sram_req,
  output logic         data_sram_wr,
  output logic [1:0]   data_sram_size,
  output logic [31:0]  data_sram_addr,
  output logic [31:0]  data_sram_wdata,
  output logic [3:0]   data_sram_wstrb,
  input  logic         data_sram_addr_ok,
  input  logic         data_sram_data_ok,
  input  logic [31:0]  data_sram_rdata,
  output logic         front_valid,
  output logic [4:0]   front_addr,
  output logic [31:0]  front_data,
  output logic [1:0]   dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  // Latched copies of the EX bundles and the captured raw load word.
  logic [144:0] zip_r;
  logic [86:0]  exc_r;
  logic [31:0]  ld_data_r;

  // Field view of the latched bundle.
  logic        valid;
  logic [31:0] pc;
  logic [31:0] ir;
  logic        ld_b, ld_bu, ld_h, ld_hu, ld_w;
  logic        st_b, st_h, st_w;
  logic        mem_we, res_from_mem, gr_we;
  logic [31:0] rkd_value;
  logic [4:0]  rf_waddr;
  logic [31:0] result;

  assign valid        = zip_r[144];
  assign pc           = zip_r[143:112];
  assign ir           = zip_r[111:80];
  assign ld_b         = zip_r[79];
  assign ld_bu        = zip_r[78];
  assign ld_h         = zip_r[77];
  assign ld_hu        = zip_r[76];
  assign ld_w         = zip_r[75];
  assign st_b         = zip_r[74];
  assign st_h         = zip_r[73];
  assign st_w         = zip_r[72];
  assign mem_we       = zip_r[71];
  assign res_from_mem = zip_r[70];
  assign gr_we        = zip_r[69];
  assign rkd_value    = zip_r[68:37];
  assign rf_waddr     = zip_r[36:32];
  assign result       = zip_r[31:0];

  // Classification of the latched and of the incoming instruction.
  logic is_load;
  logic is_store;
  logic has_except;
  logic need_mem;
  logic in_valid;
  logic in_need_mem;

  assign is_load     = ld_b | ld_bu | ld_h | ld_hu | ld_w;
  assign is_store    = st_b | st_h | st_w;
  assign has_except  = |exc_r;
  assign need_mem    = (is_load | is_store) & ~has_except;
  assign in_valid    = EX_to_MEM_zip[144];
  assign in_need_mem = (|EX_to_MEM_zip[79:72]) & ~(|EX_except_zip);

  // Handshake strobes.
  logic capture;
  logic live;
  logic mem_done;

  assign MEM_to_WB   = (state == S_DONE) & WB_allowin;
  assign MEM_allowin = ((state == S_IDLE) & ~valid) | MEM_to_WB;
  assign capture     = EX_to_MEM & MEM_allowin;
  // An instruction stays live only while no flush is pending against it.
  assign live        = valid & ~flush;
  assign mem_done    = ((state == S_WAIT) & data_sram_data_ok) |
                       ((state == S_REQ) & data_sram_addr_ok & data_sram_data_ok);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; a flushed access still finishes its SRAM handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (live) begin
          state_nxt = need_mem ? S_REQ : S_DONE;
        end
      end
      S_REQ: begin
        if (data_sram_addr_ok) begin
          if (data_sram_data_ok) begin
            state_nxt = live ? S_DONE : S_IDLE;
          end else begin
            state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (data_sram_data_ok) begin
          state_nxt = live ? S_DONE : S_IDLE;
        end
      end
      S_DONE: begin
        if (MEM_to_WB) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    // No handshake is outstanding in IDLE/DONE, so a flush drops at once.
    if (flush && ((state == S_IDLE) || (state == S_DONE))) begin
      state_nxt = S_IDLE;
    end
    // A newly accepted instruction starts its own sequence directly, which
    // gives single-cycle latency for non-memory instructions.
    if (capture) begin
      if (in_valid && !flush) begin
        state_nxt = in_need_mem ? S_REQ : S_DONE;
      end else begin
        state_nxt = S_IDLE;
      end
    end
  end

  assign dbg_state = state;

  // Input bundle capture; valid drops on flush or once handed to WB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zip_r <= '0;
      exc_r <= '0;
    end else if (capture) begin
      zip_r <= {EX_to_MEM_zip[144] & ~flush, EX_to_MEM_zip[143:0]};
      exc_r <= EX_except_zip;
    end else if (flush || MEM_to_WB) begin
      zip_r[144] <= 1'b0;
    end
  end

  // Raw load word, captured when the response arrives and held until replaced.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_data_r <= '0;
    end else if (mem_done) begin
      ld_data_r <= data_sram_rdata;
    end
  end

  // Request fields are pure functions of the latched bundle, so they stay
  // stable for as long as the FSM sits in REQ.
  assign data_sram_req  = (state == S_REQ);
  assign data_sram_wr   = mem_we;
  assign data_sram_addr = result;

  // Access size: byte, half or word.
  always_comb begin
    data_sram_size = 2'd0;
    if (ld_h || ld_hu || st_h) begin
      data_sram_size = 2'd1;
    end else if (ld_w || st_w) begin
      data_sram_size = 2'd2;
    end
  end

  // Store data replicated across lanes and the matching byte enables.
  always_comb begin
    data_sram_wdata = rkd_value;
    data_sram_wstrb = 4'b0000;
    if (st_b) begin
      data_sram_wdata = {4{rkd_value[7:0]}};
      data_sram_wstrb = 4'b0001 << result[1:0];
    end else if (st_h) begin
      data_sram_wdata = {2{rkd_value[15:0]}};
      data_sram_wstrb = result[1] ? 4'b1100 : 4'b0011;
    end else if (st_w) begin
      data_sram_wdata = rkd_value;
      data_sram_wstrb = 4'b1111;
    end
  end

  // Load extraction from the held word, selected by the low address bits.
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_value;
  logic [31:0] final_result;

  always_comb begin
    ld_byte  = 8'h00;
    ld_half  = result[1] ? ld_data_r[31:16] : ld_data_r[15:0];
    ld_value = ld_data_r;
    case (result[1:0])
      2'd0:    ld_byte = ld_data_r[7:0];
      2'd1:    ld_byte = ld_data_r[15:8];
      2'd2:    ld_byte = ld_data_r[23:16];
      default: ld_byte = ld_data_r[31:24];
    endcase
    if (ld_b) begin
      ld_value = {{24{ld_byte[7]}}, ld_byte};
    end else if (ld_bu) begin
      ld_value = {24'h000000, ld_byte};
    end else if (ld_h) begin
      ld_value = {{16{ld_half[15]}}, ld_half};
    end else if (ld_hu) begin
      ld_value = {16'h0000, ld_half};
    end
  end

  assign final_result = res_from_mem ? ld_value : result;

  // Forwarding: a load result is usable only once its data is back.
  assign front_valid = valid & gr_we & (~res_from_mem | (state == S_DONE));
  assign front_addr  = rf_waddr;
  assign front_data  = final_result;

  // WB-facing registers: load on handoff, bubble when WB drains, else hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      MEM_to_WB_reg  <= '0;
      MEM_except_reg <= '0;
    end else if (MEM_to_WB) begin
      MEM_to_WB_reg  <= {valid, pc, ir, gr_we, rf_waddr, final_result};
      MEM_except_reg <= exc_r;
    end else if (WB_allowin) begin
      MEM_to_WB_reg  <= '0;
      MEM_except_reg <= '0;
    end
  end

endmodule
